// File: rtl/alarm.sv
// alarm: serial code-entry alarm trigger.
// Bits arrive on 'in' and are committed on each rising edge of push button
// 's'. When the most recent CODE_LEN committed bits equal CODE, 'Y' is
// driven high for ALARM_CYCLES clock cycles. Both raw inputs are
// asynchronous to clk and are synchronised here. 'rst' is active-low and
// asynchronous.
module alarm #(
   parameter int unsigned         CODE_LEN     = 3,
   parameter logic [CODE_LEN-1:0] CODE         = 3'b001,
   parameter int unsigned         ALARM_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   input  logic s,
   output logic Y
);

   // Fill counter holds 0..CODE_LEN. The alarm counter holds 0..ALARM_CYCLES.
   localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
   localparam int unsigned ALM_W = $clog2(ALARM_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);
   localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(CODE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ALM_W-1:0] ALM_LOAD = ALM_W'(ALARM_CYCLES);
   localparam logic [ALM_W-1:0] ALM_ONE  = ALM_W'(1);

   // Synchroniser chain and edge-detect history.
   logic s_meta;
   logic s_sync;
   logic s_prev;
   logic in_meta;
   logic in_sync;

   // Code-entry state.
   logic [CODE_LEN-1:0] hist;
   logic [CODE_LEN-1:0] hist_next;
   logic [CNT_W-1:0]    cnt;

   // Alarm timing state.
   logic [ALM_W-1:0] alm_cnt;

   logic commit;
   logic match;

   // Two-flop synchronisers for both asynchronous inputs, plus s_prev for edge detection.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_meta  <= 1'b0;
         s_sync  <= 1'b0;
         s_prev  <= 1'b0;
         in_meta <= 1'b0;
         in_sync <= 1'b0;
      end else begin
         s_meta  <= s;
         s_sync  <= s_meta;
         s_prev  <= s_sync;
         in_meta <= in;
         in_sync <= in_meta;
      end
   end

   // One-cycle strobe per press. A held button or a release produces nothing.
   assign commit = s_sync & ~s_prev;

   // Candidate history with the newly committed bit shifted in as the LSB.
   assign hist_next = {hist[CODE_LEN-2:0], in_sync};

   // A match needs CODE_LEN genuinely entered bits. cnt is checked before this
   // commit, so leftover zeros from reset or a clear can never complete a code.
   assign match = commit && (hist_next == CODE) && (cnt >= CNT_MIN);

   // History shift register and saturating fill counter. Both are cleared on
   // a match so that consecutive codes never share bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         cnt  <= '0;
      end else if (match) begin
         hist <= '0;
         cnt  <= '0;
      end else if (commit) begin
         hist <= hist_next;
         if (cnt != CNT_FULL) begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // Alarm down-counter with a registered output. Y tracks "counter nonzero
   // after this edge", so a match while already alarming just reloads the
   // count and Y never dips low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alm_cnt <= '0;
         Y       <= 1'b0;
      end else if (match) begin
         alm_cnt <= ALM_LOAD;
         Y       <= 1'b1;
      end else if (alm_cnt != '0) begin
         alm_cnt <= alm_cnt - ALM_ONE;
         Y       <= (alm_cnt != ALM_ONE);
      end
   end

endmodule

// File: tb/tb_alarm.sv
// tb_alarm: scoreboard bench for the alarm block.
// Stimulus pushes the expected Y rise/fall events, each tagged with the
// cycle at which it should appear. A monitor pops and compares an event
// every time Y changes. Retriggers move the pending fall event, and an
// asynchronous reset pulls that fall event forward.
module tb_alarm;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic in_b = 1'b0;
   logic s    = 1'b0;
   logic y;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   logic prev_y = 1'b0;

   typedef struct {
      bit rise;
      int cyc;
   } ev_t;

   ev_t q[$];

   alarm #(
      .CODE_LEN    (3),
      .CODE        (3'b001),
      .ALARM_CYCLES(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in (in_b),
      .s  (s),
      .Y  (y)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   // Cycle index. It advances on every active edge.
   always @(posedge clk) cyc++;

   // Monitor: on every change of Y, compare against the oldest expected event.
   always @(negedge clk) begin
      if (y !== prev_y) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_y_edge: Y became %b at cycle %0d, no edge required", y, cyc);
         end else begin
            ev_t ev;
            ev = q.pop_front();
            if ((y !== logic'(ev.rise)) || (cyc != ev.cyc)) begin
               errors++;
               $display("FAIL y_edge: got Y=%b at cycle %0d, required Y=%b at cycle %0d",
                        y, cyc, ev.rise, ev.cyc);
            end
         end
         prev_y = y;
      end
   end

   // Runs a direct comparison of a single bit.
   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Records a match at edge m. If a fall is still pending at or after m, the
   // alarm is retriggered and only that fall moves. Otherwise a new pulse is
   // queued.
   task automatic expect_match(input int m);
      ev_t r;
      ev_t f;
      if ((q.size() > 0) && !q[q.size()-1].rise && (q[q.size()-1].cyc >= m)) begin
         q[q.size()-1].cyc = m + 20;
      end else begin
         r.rise = 1'b1;
         r.cyc  = m;
         f.rise = 1'b0;
         f.cyc  = m + 20;
         q.push_back(r);
         q.push_back(f);
      end
   endtask

   // Enters one bit. 'in' is set one cycle before the press, 's' is held for
   // 'hold' cycles and then released; the entry ends at a falling edge. When
   // the press is launched at cycle t, Y rises at edge t+3.
   task automatic press(input bit b, input bit exp_m, input int hold = 3);
      in_b = b;
      @(negedge clk);
      s = 1'b1;
      if (exp_m) expect_match(cyc + 3);
      repeat (hold) @(negedge clk);
      s = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Applies reset while the design is idle and checks Y during reset.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1 check("reset_y", y, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Watchdog: the run must end well before this time.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      // 1: 0,0,1 triggers one 20-cycle pulse. The clear then prevents a lone 1 from matching.
      do_reset();
      press(0, 0); press(0, 0); press(1, 1);
      idle(25);
      press(1, 0);
      idle(5);

      // 2: 0,0,1,1 gives one pulse. The trailing 1 does not alarm.
      do_reset();
      press(0, 0); press(0, 0); press(1, 1); press(1, 0);
      idle(25);

      // 3: 0,0,0,1 alarms. The following 0,1 does not, because the fill count is only 2.
      do_reset();
      press(0, 0); press(0, 0); press(0, 0); press(1, 1);
      press(0, 0); press(1, 0);
      idle(25);

      // 4: history 001 is not enough without a full count. Then 1,0,0,0,0,0 gives nothing and a final 1 matches.
      do_reset();
      press(1, 0);
      press(1, 0); press(0, 0); press(0, 0); press(0, 0); press(0, 0); press(0, 0);
      press(1, 1);
      idle(25);

      // 5a: a long press with in=1 completing 0,0 gives exactly one commit and one alarm.
      do_reset();
      press(0, 0); press(0, 0); press(1, 1, 10);
      idle(25);

      // 5b: a long press with in=0 must commit once. A following 1 then gives cnt=1 and no match.
      do_reset();
      press(0, 0, 10); press(1, 0);
      idle(10);

      // 6: an asynchronous reset mid-alarm, then a normal trigger and a retrigger while Y is high.
      do_reset();
      press(0, 0); press(0, 0); press(1, 1);
      idle(5);
      check("alarm_before_reset", y, 1'b1);
      @(negedge clk);
      q[q.size()-1].cyc = cyc + 1;
      #2 rst = 1'b0;
      #1 check("async_reset_y", y, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      press(0, 0); press(0, 0); press(1, 1);
      press(0, 0); press(0, 0); press(1, 1);
      idle(45);

      check("all_edges_seen", logic'(q.size() == 0), 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
